// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the multi-cycle fetch stage:
//   fetch_state_e - FSM state encodings (FETCH_ST, DISCARD_ST, HOLD_ST)
//   INST_BYTES    - instruction size in bytes (sequential PC step)
//   word_align()  - clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_ST   = 2'd0,
        DISCARD_ST = 2'd1,
        HOLD_ST    = 2'd2
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] INST_INCR  = 32'(INST_BYTES);

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the fetch stage's bus signals.
//   Instruction memory : imem_req, imem_addr (fetch -> mem),
//                        imem_ready, imem_rdata (mem -> fetch)
//   Delivery           : inst_valid, inst_out, pc_out (fetch -> consumer),
//                        inst_ack (consumer -> fetch)
//   Redirect           : redirect_valid, redirect_pc (consumer -> fetch)
//
// Handshakes: an imem transfer completes on a cycle with imem_req &&
// imem_ready; imem_addr is held stable until then and imem_rdata is only
// meaningful on that cycle. An instruction is retired on a cycle with
// inst_valid && inst_ack; inst_ack is ignored while inst_valid is low.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_ack;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output inst_valid, inst_out, pc_out,
        input  inst_ack,
        input  redirect_valid, redirect_pc
    );

    // Memory / consumer side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  inst_valid, inst_out, pc_out,
        output inst_ack,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instruction_fetch_unit_event_counter.sv
// ---------------------------------------------------------------------------
// event_counter
// Free-running wrap-around event counter.
//   clk, reset : clock and asynchronous active-high reset
//   en         : count one event this cycle
//   count      : current count (starts at RESET_VALUE, wraps at 2^WIDTH)
// ---------------------------------------------------------------------------
module event_counter #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Multi-cycle fetch stage: holds the PC, reads one word at a time from
// instruction memory and latches it into the instruction register (IR),
// which feeds the immediate generator / decoder downstream.
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : instruction_fetch_unit_if.master (imem, delivery, redirect)
//   fetch_count : number of acked instructions (wraps)
//   state_dbg   : current FSM state, for observation only
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus,
    output logic [31:0]               fetch_count,
    output fetch_state_e              state_dbg
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q,    pc_d;
    logic [31:0]  ir_q,    ir_d;
    logic [31:0]  pend_q,  pend_d;
    logic [31:0]  redirect_target;
    logic         count_en;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ir_d            = ir_q;
        pend_d          = pend_q;
        count_en        = 1'b0;
        redirect_target = word_align(bus.redirect_pc);

        case (state_q)
            FETCH_ST: begin
                if (bus.imem_ready) begin
                    if (bus.redirect_valid) begin
                        // Word arrived for a path that is now dead.
                        pc_d = redirect_target;
                    end else begin
                        ir_d    = bus.imem_rdata;
                        state_d = HOLD_ST;
                    end
                end else if (bus.redirect_valid) begin
                    // The transfer cannot be withdrawn, so keep the address
                    // stable, remember the target and drop the data later.
                    pend_d  = redirect_target;
                    state_d = DISCARD_ST;
                end
            end

            DISCARD_ST: begin
                if (bus.imem_ready) begin
                    // A redirect arriving together with completion is the
                    // newest target and beats the stored one.
                    pc_d    = bus.redirect_valid ? redirect_target : pend_q;
                    state_d = FETCH_ST;
                end else if (bus.redirect_valid) begin
                    pend_d = redirect_target;
                end
            end

            HOLD_ST: begin
                count_en = bus.inst_ack;
                if (bus.redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = FETCH_ST;
                end else if (bus.inst_ack) begin
                    pc_d    = pc_q + INST_INCR;
                    state_d = FETCH_ST;
                end
            end

            default: begin
                state_d = FETCH_ST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_ST;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pend_q  <= pend_d;
        end
    end

    event_counter #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0000_0000)
    ) u_fetch_counter (
        .clk   (clk),
        .reset (reset),
        .en    (count_en),
        .count (fetch_count)
    );

    // Outputs come from state and registers only. Reset gates the strobes
    // so an in-flight request disappears as soon as reset is asserted.
    assign bus.imem_req   = !reset && (state_q != HOLD_ST);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = !reset && (state_q == HOLD_ST);
    assign bus.inst_out   = ir_q;
    assign bus.pc_out     = pc_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    instruction_fetch_unit_if bus ();
    logic [31:0]  fetch_count;
    fetch_state_e state_dbg;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master),
        .fetch_count (fetch_count),
        .state_dbg   (state_dbg)
    );

    // Stand-alone counter preset just below the wrap point.
    logic        cnt_en;
    logic [31:0] cnt_val;

    event_counter #(.WIDTH(32), .RESET_VALUE(32'hFFFF_FFFE)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .count (cnt_val)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Transaction view: m_addr is the address being fetched or held,
    // m_valid says an instruction is waiting for the consumer, m_drop says
    // the outstanding read belongs to a dead path and m_target is where to
    // go once it finishes.
    logic [31:0] m_addr;
    logic        m_valid;
    logic [31:0] m_ir;
    logic        m_drop;
    logic [31:0] m_target;
    logic [31:0] m_count;

    task automatic model_reset();
        m_addr   = RST_PC;
        m_valid  = 1'b0;
        m_ir     = 32'h0;
        m_drop   = 1'b0;
        m_target = 32'h0;
        m_count  = 32'h0;
    endtask

    task automatic model_step(input logic rdy, input logic [31:0] rdata,
                              input logic ack, input logic redir,
                              input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = rpc & 32'hFFFF_FFFC;
        if (m_valid) begin
            if (ack) m_count = m_count + 1;
            if (redir) begin
                m_addr  = tgt;
                m_valid = 1'b0;
            end else if (ack) begin
                m_addr  = m_addr + 4;
                m_valid = 1'b0;
            end
        end else if (rdy) begin
            if (m_drop) begin
                m_addr = redir ? tgt : m_target;
                m_drop = 1'b0;
            end else if (redir) begin
                m_addr = tgt;
            end else begin
                m_ir    = rdata;
                m_valid = 1'b1;
            end
        end else if (redir) begin
            m_drop   = 1'b1;
            m_target = tgt;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".imem_req"},    32'(bus.imem_req),   32'(!m_valid));
        check({tag, ".imem_addr"},   bus.imem_addr,       m_addr);
        check({tag, ".inst_valid"},  32'(bus.inst_valid), 32'(m_valid));
        check({tag, ".inst_out"},    bus.inst_out,        m_ir);
        check({tag, ".pc_out"},      bus.pc_out,          m_addr);
        check({tag, ".fetch_count"}, fetch_count,         m_count);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".imem_req"},    32'(bus.imem_req),   32'h0);
        check({tag, ".imem_addr"},   bus.imem_addr,       RST_PC);
        check({tag, ".inst_valid"},  32'(bus.inst_valid), 32'h0);
        check({tag, ".inst_out"},    bus.inst_out,        32'h0);
        check({tag, ".pc_out"},      bus.pc_out,          RST_PC);
        check({tag, ".fetch_count"}, fetch_count,         32'h0);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drives inputs, advances the model, waits one
    // edge and compares at posedge+1.
    task automatic cycle(input string tag, input logic rdy,
                         input logic [31:0] rdata, input logic ack,
                         input logic redir, input logic [31:0] rpc);
        bus.imem_ready     = rdy;
        bus.imem_rdata     = rdata;
        bus.inst_ack       = ack;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        model_step(rdy, rdata, ack, redir, rpc);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        bus.imem_ready     = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.inst_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    // ---------------- stimulus ----------------
    logic        r_rdy, r_ack, r_redir;
    logic [31:0] r_data, r_pc;

    initial begin
        reset  = 1'b1;
        cnt_en = 1'b0;
        idle_inputs();
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        check("reset.state", 32'(state_dbg), 32'(FETCH_ST));
        reset = 1'b0;
        #1;
        compare_all("after_reset");

        // Zero-wait fetch from RESET_PC, then ack.
        cycle("t1_fetch", 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        check("t1_inst", bus.inst_out, 32'h0050_0093);
        check("t1_pc", bus.pc_out, 32'h0000_0100);
        cycle("t1_ack", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t1_next_addr", bus.imem_addr, 32'h0000_0104);

        // Wait states in FETCH.
        for (int i = 0; i < 3; i++) cycle("t2_wait", 1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        check("t2_addr_stable", bus.imem_addr, 32'h0000_0104);
        cycle("t2_done", 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        cycle("t2_ack", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Redirect while ready low -> DISCARD, stale data dropped.
        cycle("t3_redir", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0203);
        check("t3_state", 32'(state_dbg), 32'(DISCARD_ST));
        check("t3_old_addr", bus.imem_addr, 32'h0000_0108);
        cycle("t3_wait", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle("t3_stale", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check("t3_new_addr", bus.imem_addr, 32'h0000_0200);
        cycle("t3_fetch", 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
        check("t3_no_stale", 32'(bus.inst_out == 32'hDEAD_BEEF), 32'h0);

        // Redirect + ack in HOLD at PC 0x40.
        cycle("t4_to40", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
        cycle("t4_drop", 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        cycle("t4_fetch", 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
        check("t4_pc", bus.pc_out, 32'h0000_0040);
        cycle("t4_redir_ack", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080);
        check("t4_addr", bus.imem_addr, 32'h0000_0080);
        check("t4_count", fetch_count, 32'h0000_0003);

        // PC wrap.
        cycle("t5_redir", 1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle("t5_fetch", 1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0);
        cycle("t5_ack", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t5_wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Counter wrap on the stand-alone instance.
        check("cnt_preset", cnt_val, 32'hFFFF_FFFE);
        cnt_en = 1'b1;
        @(posedge clk); #1;
        check("cnt_max", cnt_val, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("cnt_wrap", cnt_val, 32'h0000_0000);
        cnt_en = 1'b0;
        @(posedge clk); #1;
        check("cnt_hold", cnt_val, 32'h0000_0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_rdy   = ($urandom_range(0, 2) != 0);
            r_ack   = ($urandom_range(0, 1) != 0);
            r_redir = ($urandom_range(0, 7) == 0);
            r_data  = $urandom;
            r_pc    = $urandom;
            cycle("rand", r_rdy, r_data, r_ack, r_redir, r_pc);
        end

        // Async reset mid-DISCARD.
        cycle("t6_pre", 1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
        cycle("t6_redir", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0400);
        check("t6_state", 32'(state_dbg), 32'(DISCARD_ST));
        idle_inputs();
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("t6_async");
        check("t6_state_rst", 32'(state_dbg), 32'(FETCH_ST));
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        compare_all("t6_restart");
        check("t6_addr", bus.imem_addr, RST_PC);
        cycle("t6_fetch", 1'b1, 32'h0000_0113, 1'b0, 1'b0, 32'h0);
        cycle("t6_ack", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("t6_count", fetch_count, 32'h0000_0001);

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Multi-cycle fetch stage: holds the PC, issues word reads to instruction memory over a req/ready handshake, and latches the returned word into an instruction register (IR). The IR drives the `inst` bus of the immediate generator and decoder directly downstream. Branch/JAL targets computed from the generated immediate come back as a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address; bits [1:0] always 0.
- `imem_ready`  in  1  transfer completes on a cycle with `imem_req` && `imem_ready`.
- `imem_rdata`  in  32  read data, valid only on the completing cycle.
- `inst_valid`  out  1  IR holds a deliverable instruction.
- `inst_out`  out  32  IR contents, feeding the immediate generator's `inst`.
- `pc_out`  out  32  address of `inst_out`.
- `inst_ack`  in  1  consumer retires the current instruction; ignored unless `inst_valid`.
- `redirect_valid`  in  1  replace the sequential PC.
- `redirect_pc`  in  32  target; bits [1:0] are forced to 0.
- `fetch_count`  out  32  number of instructions delivered (acked), wraps.

## Operation
- States: FETCH, DISCARD, HOLD.
- FETCH: `imem_req`=1, `imem_addr`=PC.
  - ready && !redirect: IR<=rdata, go to HOLD.
  - ready && redirect: drop the data, PC<=redirect_pc, stay in FETCH.
  - !ready && redirect: pend<=redirect_pc, go to DISCARD.
- DISCARD: `imem_req`=1, `imem_addr`=old PC (address stays stable mid-transfer).
  - A later redirect overwrites pend; the latest one wins.
  - On ready: drop the data, PC<=pend, go to FETCH.
- HOLD: `imem_req`=0, `inst_valid`=1.
  - ack && !redirect: PC<=PC+4, fetch_count++, go to FETCH.
  - redirect, with or without ack: PC<=redirect_pc, go to FETCH. fetch_count increments only if ack is also high.
  - Neither: hold the IR; `inst_out` and `pc_out` stay stable.
- `imem_addr` must not change while `imem_req`=1 and the transfer is incomplete.
- PC+4 wraps modulo 2^32 (FFFF_FFFC -> 0000_0000).
- Discarded data never reaches the IR.
- Reset, asynchronous at any point:
  - state=FETCH, PC=RESET_PC, IR=0, pend=0, fetch_count=0.
  - `inst_valid`=0 and `imem_req`=0 while reset is asserted; an in-flight transfer is abandoned.

## Timing
- Reset values: `imem_req` 0, `imem_addr` RESET_PC, `inst_valid` 0, `inst_out` 0, `pc_out` RESET_PC, `fetch_count` 0.
- First edge after reset deassertion: `imem_req`=1 combinationally from FETCH.
- Ready at cycle N: `inst_valid`=1 at cycle N+1.
- Ack at cycle M: `imem_req`=1 at cycle M+1 with the new address.
- Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Outputs decode from state and registers only; there is no combinational path from `imem_rdata` to `inst_out`.

## Structure
- Shared header `fetch_defs.v`, used alongside `opcodes.v`:
  - state encodings `FETCH_ST`, `DISCARD_ST`, `HOLD_ST` (2-bit);
  - `INST_BYTES` (4).
- One natural sub-module, `event_counter` (32-bit, enable, async reset), for `fetch_count`. The rest is a single always block for state/PC/IR plus combinational output decode.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory returning 0x00500093 -> `imem_addr` 0x100; `inst_valid` one cycle after the transfer; `inst_out`=0x00500093, `pc_out`=0x100; after ack, next `imem_addr`=0x104.
- Ready held low 3 cycles in FETCH -> `imem_addr` stable; `inst_valid` 0 throughout.
- Redirect to 0x203 while ready is low, ready arriving 2 cycles later -> DISCARD entered; stale word never appears on `inst_out`; next request address 0x200.
- Redirect in HOLD together with ack, PC=0x40, target 0x80 -> next `imem_addr`=0x80 (not 0x44); `fetch_count` increments by 1.
- PC=0xFFFF_FFFC acked -> next `imem_addr`=0x0. `fetch_count` preset near wrap via 2^32 acks is replaced by checking 0xFFFF_FFFF -> 0 on the counter alone.
- Async reset asserted mid-DISCARD -> outputs return to reset values within the same cycle, without waiting for `clk`; the fetch restarts at RESET_PC.
